// File: rtl/lab4_pkg.sv
// Shared definitions for the lab 4 sequential divider: FSM state encoding
// and default datapath sizing.
package lab4_pkg;

  localparam int WIDTH_DEF = 5;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lab4_div5_ctrl_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
// The requester drives the master side; the divider is the slave.
interface lab4_div5_ctrl_if #(
  parameter int WIDTH = lab4_pkg::WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic             out_dz;

  modport master (
    output start, in_dividend, in_divisor,
    input  busy, done, out_q, out_r, out_dz
  );

  modport slave (
    input  start, in_dividend, in_divisor,
    output busy, done, out_q, out_r, out_dz
  );

endinterface

// File: rtl/lab4_sub_n.sv
// N-bit ripple subtractor a + ~b + cin built as a full-adder chain.
// cout_o high means no borrow, i.e. a >= b when cin_i is 1.
module lab4_sub_n #(
  parameter int N = 6
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] diff_o,
  output logic         cout_o
);

  logic [N-1:0] b_inv;
  logic [N:0]   carry;

  assign b_inv    = ~b_i;
  assign carry[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign diff_o[i]  = a_i[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_inv[i]) | (a_i[i] & carry[i]) | (b_inv[i] & carry[i]);
  end

  assign cout_o = carry[N];

endmodule

// File: rtl/lab4_div5_ctrl.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock on
// a single shared ripple subtractor, with start/busy/done handshake.
module lab4_div5_ctrl
  import lab4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  lab4_div5_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic             take_diff;

  // Trial value {R, next dividend bit} minus {0, D}; carry-out means it fits.
  lab4_sub_n #(
    .N (WIDTH + 1)
  ) u_sub (
    .a_i    ({r_q, q_q[WIDTH-1]}),
    .b_i    ({1'b0, d_q}),
    .cin_i  (1'b1),
    .diff_o (diff),
    .cout_o (no_borrow)
  );

  // The partial remainder stays below D, so a successful difference always
  // has a clear msb; folding that bit in keeps the accept condition exact.
  assign take_diff = no_borrow & ~diff[WIDTH];

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.in_divisor == '0) begin
            q_d     = '1;
            r_d     = bus.in_dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            d_d     = bus.in_divisor;
            q_d     = bus.in_dividend;
            r_d     = '0;
            dz_d    = 1'b0;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (take_diff) begin
          r_d = diff[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.out_q  = q_q;
  assign bus.out_r  = r_q;
  assign bus.out_dz = dz_q;

endmodule

// File: doc/lab4_div5_ctrl.md
Name: lab4_div5_ctrl

Overview:
- Sequential controller that time-shares one ripple subtractor to perform unsigned WIDTH-bit restoring division.
- Uses one subtract per clock, with start/busy/done handshake.
- Sits beside the 5-bit adder/subtractor datapath and is the lab's first multi-cycle arithmetic unit.
- Produces quotient, remainder and a divide-by-zero flag.

Parameters:
WIDTH, 5, operand/quotient/remainder width in bits (tested at 5 only)
CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > WIDTH-1

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
in_dividend  input  WIDTH  dividend, captured on accepted start
in_divisor  input  WIDTH  divisor, captured on accepted start
busy  output  1  high in CALC and DONE
done  output  1  one-cycle pulse: results valid
out_q  output  WIDTH  quotient
out_r  output  WIDTH  remainder
out_dz  output  1  divide-by-zero flag for last operation

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, busy=0, done=0, out_q=0, out_r=0, out_dz=0, counter=0.
  - Overrides everything, including mid-CALC; the aborted operation produces no done.
- States and transitions:
  - IDLE: start=1 with divisor!=0 captures D=in_divisor, Q=in_dividend, R=0, out_dz=0, counter=WIDTH-1, then goes to CALC.
  - IDLE: start=1 with divisor==0 loads out_q=all ones (31), out_r=in_dividend, out_dz=1, then goes directly to DONE.
  - CALC: one iteration per clock (see below). When counter==0 at the edge, perform the last iteration and go to DONE; otherwise decrement counter.
  - DONE: done=1 for exactly this cycle, then unconditionally return to IDLE.
- Iteration, restoring:
  - trial = {R, Q[WIDTH-1]} is WIDTH+1 bits.
  - diff = trial + ~{1'b0,D} + 1, computed on the sub-module with carry-in 1.
  - Carry-out=1 (no borrow): R=diff[WIDTH-1:0], Q={Q[WIDTH-2:0],1}.
  - Carry-out=0: R=trial[WIDTH-1:0], Q={Q[WIDTH-2:0],0}.
- Outputs: out_q=Q and out_r=R are continuously driven from the registers. They are valid when done=1 and held stable until the next accepted start.
- Latency:
  - Start accepted at edge k; iterations at edges k+1..k+WIDTH.
  - done=1 in the cycle after edge k+WIDTH, i.e. 6 cycles for WIDTH=5.
  - Divide-by-zero: done=1 in the cycle after edge k (1-cycle latency).
- Handshake:
  - start is ignored while busy=1, including during DONE. No queuing.
  - start held high continuously yields back-to-back operations with one IDLE cycle between done and the next acceptance.
  - Operands are captured at acceptance; input changes afterwards have no effect.
- Arithmetic: all unsigned, no overflow possible; out_q*divisor+out_r == dividend whenever out_dz=0.

Decomposition:
- Shared package (lab4_pkg):
  - state encoding localparams: IDLE=2'd0, CALC=2'd1, DONE=2'd2
  - WIDTH default
- Sub-module: lab4_sub_n (WIDTH+1-bit ripple subtractor, a + ~b + cin, carry-out = no-borrow), built from lab4_2 full-adder chain style. Instantiate exactly once.
- The controller holds only the FSM, counter and registers.

Test Plan:
- Reset, then start with dividend=23, divisor=4 -> done 6 cycles later with out_q=5, out_r=3, out_dz=0; busy high for 6 cycles.
- 31/1 -> out_q=31, out_r=0; 3/9 -> out_q=0, out_r=3; 31/31 -> out_q=1, out_r=0.
- 7/0 -> done 1 cycle after start, out_dz=1, out_q=31, out_r=7; following 10/3 -> out_dz=0, out_q=3, out_r=1.
- Start 20/6, then pulse start with 9/2 and change operands during CALC -> ignored; result out_q=3, out_r=2; done pulses exactly once.
- Assert reset_n=0 at the 3rd CALC cycle of 25/7 -> all outputs 0 next cycle, no done; a new start of 25/7 -> out_q=3, out_r=4.
- Exhaustive sweep of all 32x32 operand pairs against a reference model (quotient, remainder, dz, 6-cycle latency); start held high -> one IDLE gap between operations.
